// File: rtl/conv_window_gen_pkg.sv
// conv_pkg: shared FSM state type and geometry helpers for conv_window_gen
// Provides the state enum, the padding function and counter-width helpers.
package conv_pkg;
    typedef enum logic [1:0] {LOAD, STREAM, DRAIN} state_t;
    function automatic int pad(input int k);
        return (k - 1) / 2;
    endfunction
    function automatic int col_w(input int w);
        return $clog2(w);
    endfunction
    function automatic int row_w(input int h);
        return $clog2(h + 1);
    endfunction
    function automatic int slot_w(input int k);
        return $clog2(k + 1);
    endfunction
endpackage

// File: rtl/conv_window_gen_if.sv
// conv_window_gen_if: pixel-in / window-out handshake bundle
// i_data/i_valid/o_ready carry input pixels; o_window/o_valid/i_ready/o_last carry windows.
interface conv_window_gen_if #(
    parameter int K = 3,
    parameter int C = 1,
    parameter int B = 8
);
    logic [C*B-1:0]     i_data;
    logic               i_valid;
    logic               o_ready;
    logic [K*K*C*B-1:0] o_window;
    logic               o_valid;
    logic               i_ready;
    logic               o_last;
    modport master (output i_data, i_valid, i_ready, input o_ready, o_window, o_valid, o_last);
    modport slave  (input i_data, i_valid, i_ready, output o_ready, o_window, o_valid, o_last);
endinterface

// File: rtl/conv_window_gen_window_ring.sv
// window_ring: K+1 row ring buffer with zero-padded KxK window gather
// Ports: write port (i_we, i_wslot, i_wcol, i_wdata); gather at (i_row, i_col) when i_en -> o_window.
module window_ring import conv_pkg::*; #(
    parameter int W = 28,
    parameter int H = 28,
    parameter int K = 3,
    parameter int C = 1,
    parameter int B = 8
) (
    input  logic                      i_clk,
    input  logic                      i_we,
    input  logic [slot_w(K)-1:0]      i_wslot,
    input  logic [col_w(W)-1:0]       i_wcol,
    input  logic [C*B-1:0]            i_wdata,
    input  logic                      i_en,
    input  logic [row_w(H)-1:0]       i_row,
    input  logic [col_w(W)-1:0]       i_col,
    output logic [K*K*C*B-1:0]        o_window
);
    localparam int P  = pad(K);
    localparam int SW = slot_w(K);
    localparam int CW = col_w(W);

    logic [C*B-1:0] ring_q [K+1][W];

    always_ff @(posedge i_clk)
        if (i_we) ring_q[i_wslot][i_wcol] <= i_wdata;

    // Rows/cols outside the frame read as zero: this is the same-size padding.
    always_comb begin
        o_window = '0;
        for (int i = 0; i < K; i++)
            for (int j = 0; j < K; j++)
                if (i_en && int'(i_row) + i >= P && int'(i_row) + i - P < H &&
                    int'(i_col) + j >= P && int'(i_col) + j - P < W)
                    o_window[(i*K+j)*C*B +: C*B] =
                        ring_q[SW'((int'(i_row) + i - P) % (K + 1))][CW'(int'(i_col) + j - P)];
    end
endmodule

// File: rtl/conv_window_gen.sv
// conv_window_gen: streaming KxK window generator with same-size zero padding
// Ports: i_clk, i_rst (sync, active-high), bus (slave): pixel stream in, window stream out.
module conv_window_gen import conv_pkg::*; #(
    parameter int W = 28,
    parameter int H = 28,
    parameter int K = 3,
    parameter int C = 1,
    parameter int B = 8
) (
    input logic              i_clk,
    input logic              i_rst,
    conv_window_gen_if.slave bus
);
    localparam int P  = pad(K);
    localparam int CW = col_w(W);
    localparam int RW = row_w(H);
    localparam int SW = slot_w(K);

    state_t          state_q, state_d;
    logic [RW-1:0]   in_row_q, in_row_d, out_row_q, out_row_d;
    logic [CW-1:0]   in_col_q, in_col_d, out_col_q, out_col_d;
    logic            row_avail, in_hs, out_hs, last_hs;
    logic [K*K*C*B-1:0] window;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q   <= LOAD;
            in_row_q  <= '0;
            in_col_q  <= '0;
            out_row_q <= '0;
            out_col_q <= '0;
        end else begin
            state_q   <= state_d;
            in_row_q  <= in_row_d;
            in_col_q  <= in_col_d;
            out_row_q <= out_row_d;
            out_col_q <= out_col_d;
        end
    end

    // Next state uses the post-edge input row so the first window is valid
    // in the cycle right after the row that completes its neighbourhood.
    always_comb begin
        in_row_d  = in_row_q;
        in_col_d  = in_col_q;
        out_row_d = out_row_q;
        out_col_d = out_col_q;
        if (in_hs) begin
            in_col_d = (int'(in_col_q) == W - 1) ? '0 : in_col_q + 1'b1;
            in_row_d = (int'(in_col_q) == W - 1) ? in_row_q + 1'b1 : in_row_q;
        end
        if (out_hs) begin
            out_col_d = (int'(out_col_q) == W - 1) ? '0 : out_col_q + 1'b1;
            out_row_d = (int'(out_col_q) == W - 1) ? out_row_q + 1'b1 : out_row_q;
        end
        state_d = (state_q == LOAD   && int'(in_row_d) >= P + 1) ? STREAM :
                  (state_q == STREAM && int'(in_row_d) == H)     ? DRAIN  : state_q;
        if (last_hs) begin
            in_row_d  = '0;
            in_col_d  = '0;
            out_row_d = '0;
            out_col_d = '0;
            state_d   = LOAD;
        end
    end

    // Input is held back once it is P+1 rows ahead, so the ring slot being
    // written never belongs to a row the current output row still reads.
    always_comb begin
        row_avail   = int'(in_row_q) >= ((int'(out_row_q) + P + 1 < H) ? int'(out_row_q) + P + 1 : H);
        bus.o_valid = row_avail && state_q != LOAD;
        bus.o_ready = state_q != DRAIN && int'(in_row_q) < H && int'(in_row_q) <= int'(out_row_q) + P + 1;
        bus.o_last  = bus.o_valid && int'(out_row_q) == H - 1 && int'(out_col_q) == W - 1;
        in_hs       = bus.i_valid && bus.o_ready;
        out_hs      = bus.o_valid && bus.i_ready;
        last_hs     = out_hs && bus.o_last;
    end

    assign bus.o_window = window;

    window_ring #(.W(W), .H(H), .K(K), .C(C), .B(B)) u_ring (
        .i_clk   (i_clk),
        .i_we    (in_hs),
        .i_wslot (SW'(int'(in_row_q) % (K + 1))),
        .i_wcol  (in_col_q),
        .i_wdata (bus.i_data),
        .i_en    (bus.o_valid),
        .i_row   (out_row_q),
        .i_col   (out_col_q),
        .o_window(window)
    );
endmodule

// File: doc/conv_window_gen.md
# conv_window_gen

Streaming K×K convolution window generator with same-size zero padding. It accepts a row-major pixel stream of an H×W, C-channel feature map and emits one K×K×C window per output pixel, W×H windows per frame, in row-major order. It sits between the feature-map source and the MAC array of the conv layers. It replaces the single-line, 3-tap, no-handshake line buffer with configurable geometry, multi-row storage, valid/ready flow control on both sides and end-of-frame drain.

## Interface
- W, 28, feature-map width in pixels (W ≥ K)
- H, 28, feature-map height in rows (H ≥ K)
- K, 3, kernel size; odd, ≥ 3; P = (K-1)/2 is the padding
- C, 1, channels per pixel
- B, 8, bits per channel sample

Ports:
- i_clk  in  1  clock
- i_rst  in  1  reset, synchronous, active-high
- i_data  in  C*B  input pixel; channel c at bits [c*B +: B]
- i_valid  in  1  input pixel valid
- o_ready  out  1  block accepts input pixel
- o_window  out  K*K*C*B  output window; element (i,j), channel c at bits [((i*K+j)*C+c)*B +: B]; i = row (0 = top), j = column (0 = left)
- o_valid  out  1  window valid
- i_ready  in  1  consumer accepts window
- o_last  out  1  current window is the last of the frame (row H-1, col W-1)

## Operation
- Storage: a ring of K+1 rows × W pixels. Input row r is written to slot r mod (K+1).
- Counters: in_row/in_col give the next input position. in_row ∈ [0,H]; in_row = H means the input frame is complete. out_row/out_col give the next output position.
- Input handshake: a pixel is accepted on i_valid & o_ready. in_col wraps at W-1 and increments in_row.
- o_ready = (state ≠ DRAIN) & (in_row < H) & (in_row ≤ out_row + P + 1). The last term prevents overwriting a row the current output row still needs.
- Output row out_row becomes available when in_row ≥ min(out_row + P + 1, H).
- o_valid = row available & state ≠ LOAD-before-first-row.
- Output handshake: o_valid & i_ready. out_col wraps at W-1 and increments out_row.
- Window element (i,j) = pixel (out_row+i-P, out_col+j-P). It is 0 when the row is outside [0,H-1] or the column is outside [0,W-1].
- o_window is all-zero whenever o_valid = 0.
- o_last = o_valid & out_row = H-1 & out_col = W-1.
- FSM states:
  - LOAD: no window valid yet. Go to STREAM when in_row reaches min(P+1, H).
  - STREAM: input and output both active. Go to DRAIN when in_row = H.
  - DRAIN: input blocked; remaining rows are emitted with bottom padding. On the o_last handshake, clear all counters and go to LOAD.
- Input and output handshakes in the same cycle are both honoured. Occupancy is evaluated from pre-edge counters.

## Timing
- Reset values: state = LOAD, all counters 0, o_ready = 1, o_valid = 0, o_last = 0, o_window = 0. Ring contents are not reset.
- i_rst mid-frame aborts the frame. The next accepted pixel is position (0,0).
- Counters and ring are registered. o_window, o_valid, o_ready and o_last are combinational from registered state (zero-latency prefetch).
- First o_valid is asserted in the cycle after the handshake of pixel (P, W-1).
- With no stalls, throughput is 1 window per cycle in STREAM.
- In DRAIN, the remaining P rows plus any pending windows are output at 1 per cycle.
- The next frame's first pixel can be accepted in the cycle after the o_last handshake.

## Structure
- Package conv_pkg holds:
  - the state enum (LOAD, STREAM, DRAIN);
  - a localparam function for the pad P = (K-1)/2;
  - counter-width helpers ($clog2(W), $clog2(H+1), $clog2(K+1)).
- One sub-module, window_ring, covers the K+1 row ring storage, the write port (slot, column, data) and the combinational K×K×C gather with zero-pad masking.
- The top level holds the counters, FSM, handshake logic and o_last.

## Test plan
- W=H=5, K=3, C=1, B=8, pixel(r,c) = 5r+c+1, continuous valid/ready → exactly 25 windows, checked as rows i = 0,1,2:
  - window(0,0) = {0,0,0; 0,1,2; 0,6,7};
  - window(2,2) = {7,8,9; 12,13,14; 17,18,19};
  - window(4,4) = {19,20,0; 24,25,0; 0,0,0};
  - o_last is high only on the 25th window.
- Same geometry, i_ready held 0 from reset → exactly 15 pixels accepted, then o_ready = 0 and o_valid = 1 with window(0,0) held stable.
- Full frame accepted, i_ready toggling → o_ready stays 0 through DRAIN until the o_last handshake. A new-frame pixel is accepted the next cycle, and its row values appear in window(0,0) of frame 2.
- i_rst pulse after 12 pixels → o_valid = 0, o_ready = 1, o_last = 0. Frame 2 output matches case 1 exactly.
- W=H=6, K=5, C=2, ch0 = 6r+c, ch1 = 100+6r+c → window(0,0) has rows 0-1 and columns 0-1 zero. Element (2,2) = {ch1 = 100, ch0 = 0} at bits [(12*2)*8 +: 16].
- W=7, H=5, K=3, random i_valid/i_ready (50%), 3 back-to-back frames → all windows match the golden model, and o_valid/o_window are stable while i_ready = 0.
